lcd_panel_model: RTL and testbench
==================================

// Module: lcd_panel_model
// PURPOSE
//  Synthesizable responder for the 4-chip KS0108-style LCD bus that Driver initiates (db/dori/cs/en/rw/rst).
//  Decodes each bus cycle per chip and keeps display RAM, Y/page/start-line registers and the on/off flag.
//  Exposes a framebuffer read port addressed exactly like Driver's 11-bit addr ({chip,page,y}).
//  Lets the team loop Driver+Decider back on-chip or in simulation and compare against Texture/Decider output.
// PARAMETERS
//  NUM_CS       4   number of controller chips, one per cs_i bit; 64 columns x 8 pages each
//  BUSY_CYCLES  3   clk cycles the busy flag stays high after each accepted write cycle (>=1)
// PORTS
//  clk        in   1   system clock, same domain as Driver
//  rstn       in   1   asynchronous active-low reset
//  db_i       in   8   bus data from Driver
//  dori_i     in   1   0 = instruction, 1 = display data
//  cs_i       in   4   chip selects, active high, bit n selects chip n
//  en_i       in   1   bus strobe; cycle committed on falling edge
//  rw_i       in   1   0 = write, 1 = read
//  rst_i      in   1   panel reset, active low, level-sensitive
//  db_o       out  8   read-back data (LCD_MODEL_RDBACK_EN only)
//  db_oe      out  1   db_o valid/drive enable
//  busy_o     out  1   any chip busy
//  disp_on_o  out  4   per-chip display-on flag
//  fb_addr_i  in  11   framebuffer read address {chip[1:0],page[2:0],y[5:0]}
//  fb_data_o  out  8   byte at fb_addr_i, registered, 1-cycle latency
//  err_o      out  1   sticky: write accepted while target chip busy, or illegal instruction
// BEHAVIOUR
//  Reset (rstn=0): all outputs 0; per-chip Y=0, page=0, start=0, on=0, busy cnt=0; RAM not cleared.
//  rst_i=0 while rstn=1: same register clear as rstn except err_o held; bus cycles ignored.
//  Strobe: en_i registered once; falling edge (1->0) with rw_i=0 latches db_i, dori_i, cs_i in that cycle.
//  cs_i==0 at falling edge: cycle ignored, no state change.
//  FSM IDLE -> DECODE (1 clk) -> APPLY (one clk per selected chip, ascending index) -> IDLE.
//  A new falling edge during DECODE/APPLY is dropped and sets err_o.
//  Instructions (dori=0), applied to every selected chip:
//   0011111D (0x3E/0x3F): on = D
//   01YYYYYY: Y = db[5:0]
//   10111PPP (0xB8..0xBF): page = db[2:0]
//   11LLLLLL: start = db[5:0]
//   other codes: no state change, err_o=1
//  Data write (dori=1): RAM[chip,page,Y] = byte, then Y = Y+1 mod 64.
//   Y=63 wraps to 0; page never auto-increments.
//  Busy: each applied chip loads busy cnt = BUSY_CYCLES, decrements to 0.
//   busy_o = OR of chip counters.
//   Write committed to a chip with cnt!=0 still executes; err_o=1.
//  RAM: single array NUM_CS*512 x 8.
//   Write port owned by APPLY; read port fb_addr_i -> fb_data_o registered.
//   Same-cycle write and read of the same address returns old data.
//  start line is stored and reported only; fb port is never rotated by it.
// CONFIGURATION
//  LCD_MODEL_RDBACK_EN defined: rw_i=1 cycles are decoded, one selected chip, lowest index wins.
//   While en_i=1, db_oe=1.
//   Status read (dori=0): db_o = {busy,0,~on,~rst_i,4'b0}.
//   Data read (dori=1): db_o = output latch.
//   On the falling edge of a data read, the latch is loaded with RAM[page,Y] and Y increments.
//   The first read after an address set is therefore a dummy read.
//  Not defined: rw_i=1 cycles are ignored entirely; db_o=0, db_oe=0 constant.
// TESTING
//  1 rstn pulse -> all outputs 0; disp_on_o=0000; fb reads of any address are stable (no X on regs).
//  2 cs=0001: write 0x3F, 0xB9, 0x45, then data 0xA5 -> fb_addr {00,001,000101} reads 0xA5; Y becomes 6; disp_on_o=0001.
//  3 cs=0010, Y=63: data 0x11, 0x22 -> addr {01,pg,63}=0x11 and {01,pg,0}=0x22 (wrap, page unchanged).
//  4 cs=1111, Y=0x40, page 0xB8, data 0xFF -> 4 APPLY cycles; byte 0xFF at y=0 of all 4 chips; busy_o high >= BUSY_CYCLES.
//  5 Second en falling edge 2 clk after the first -> second write dropped and err_o=1; 0x3A with dori=0 -> err_o=1.
//  6 RDBACK_EN: set Y=5, then two data reads -> second read db_o = RAM[5]; rst_i=0 mid-sequence -> Y=0, on=0, RAM kept.

Source files
------------

// File: rtl/lcd_panel_model.sv
// Bus responder for a 4-chip KS0108-style LCD: decodes Driver bus cycles, keeps per-chip registers
// and display RAM, and offers a registered framebuffer read port. Optional read-back: LCD_MODEL_RDBACK_EN.
module lcd_panel_model #(
  parameter int unsigned NUM_CS      = 4,
  parameter int unsigned BUSY_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [7:0]                db_i,
  input  logic                      dori_i,
  input  logic [NUM_CS-1:0]         cs_i,
  input  logic                      en_i,
  input  logic                      rw_i,
  input  logic                      rst_i,
  output logic [7:0]                db_o,
  output logic                      db_oe,
  output logic                      busy_o,
  output logic [NUM_CS-1:0]         disp_on_o,
  input  logic [$clog2(NUM_CS)+8:0] fb_addr_i,
  output logic [7:0]                fb_data_o,
  output logic                      err_o
);
  localparam int unsigned CW = $clog2(NUM_CS);
  localparam int unsigned BW = $clog2(BUSY_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_APPLY} state_t;
  typedef enum logic [2:0] {OP_ON, OP_Y, OP_PAGE, OP_START, OP_DATA, OP_BAD} op_t;

  state_t              state_q, state_d;
  op_t                 op;
  logic [7:0]          ram [NUM_CS*512];
  logic [5:0]          y_q      [NUM_CS];
  logic [2:0]          page_q   [NUM_CS];
  logic [5:0]          start_q  [NUM_CS];
  logic [BW-1:0]       busy_cnt [NUM_CS];
  logic [NUM_CS-1:0]   on_q;
  logic [NUM_CS-1:0]   pend_q;
  logic [NUM_CS-1:0]   pend_rest;
  logic [7:0]          data_q;
  logic                dori_q;
  logic                en_q;
  logic                fall;
  logic                bus_cycle;
  logic                accept_wr;
  logic                drop;
  logic [CW-1:0]       cur_idx;
  logic                wr_en;
  logic [CW+8:0]       wr_addr;

  assign fall = en_q & ~en_i;
`ifdef LCD_MODEL_RDBACK_EN
  logic [7:0]    rd_latch [NUM_CS];
  logic [CW-1:0] rd_idx;
  logic          accept_rd;
  assign bus_cycle = fall & rst_i & (|cs_i);
  assign accept_rd = bus_cycle & rw_i & (state_q == S_IDLE);

  always_comb begin
    rd_idx = '0;
    for (int unsigned i = NUM_CS; i > 0; i--)
      if (cs_i[i-1]) rd_idx = CW'(i - 1);
  end

  always_comb begin
    db_oe = rstn & en_i & rw_i;
    db_o  = '0;
    if (db_oe)
      db_o = dori_i ? rd_latch[rd_idx]
                    : {busy_cnt[rd_idx] != '0, 1'b0, ~on_q[rd_idx], ~rst_i, 4'b0000};
  end
`else
  assign bus_cycle = fall & rst_i & (|cs_i) & ~rw_i;
  assign db_o      = '0;
  assign db_oe     = 1'b0;
`endif
  assign accept_wr = bus_cycle & ~rw_i & (state_q == S_IDLE);
  assign drop      = bus_cycle & (state_q != S_IDLE);

  always_comb begin
    op = OP_BAD;
    if (dori_q)                         op = OP_DATA;
    else if (data_q[7:1] == 7'b0011111) op = OP_ON;
    else if (data_q[7:6] == 2'b01)      op = OP_Y;
    else if (data_q[7:3] == 5'b10111)   op = OP_PAGE;
    else if (data_q[7:6] == 2'b11)      op = OP_START;
  end

  // Chips still pending are served lowest index first, one per APPLY cycle.
  always_comb begin
    cur_idx = '0;
    for (int unsigned i = NUM_CS; i > 0; i--)
      if (pend_q[i-1]) cur_idx = CW'(i - 1);
    pend_rest = pend_q & ~(NUM_CS'(1) << cur_idx);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept_wr) state_d = S_DECODE;
      S_DECODE: state_d = (op == OP_BAD) ? S_IDLE : S_APPLY;
      S_APPLY:  if (pend_rest == '0) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (!rst_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  assign wr_en   = (state_q == S_APPLY) && (op == OP_DATA) && rst_i;
  assign wr_addr = {cur_idx, page_q[cur_idx], y_q[cur_idx]};

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= data_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) fb_data_o <= '0;
    else       fb_data_o <= ram[fb_addr_i];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q   <= 1'b0;
      data_q <= '0;
      dori_q <= 1'b0;
      pend_q <= '0;
      on_q   <= '0;
      err_o  <= 1'b0;
      for (int unsigned i = 0; i < NUM_CS; i++) begin
        y_q[i]      <= '0;
        page_q[i]   <= '0;
        start_q[i]  <= '0;
        busy_cnt[i] <= '0;
`ifdef LCD_MODEL_RDBACK_EN
        rd_latch[i] <= '0;
`endif
      end
    end else begin
      en_q <= en_i;
      for (int unsigned i = 0; i < NUM_CS; i++)
        if (busy_cnt[i] != '0) busy_cnt[i] <= busy_cnt[i] - BW'(1);
      if (!rst_i) begin
        pend_q <= '0;
        on_q   <= '0;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
          y_q[i]      <= '0;
          page_q[i]   <= '0;
          start_q[i]  <= '0;
          busy_cnt[i] <= '0;
`ifdef LCD_MODEL_RDBACK_EN
          rd_latch[i] <= '0;
`endif
        end
      end else begin
        if (drop) err_o <= 1'b1;
        if (accept_wr) begin
          data_q <= db_i;
          dori_q <= dori_i;
          pend_q <= cs_i;
          for (int unsigned i = 0; i < NUM_CS; i++)
            if (cs_i[i] && busy_cnt[i] != '0) err_o <= 1'b1;
        end
        if (state_q == S_DECODE && op == OP_BAD) err_o <= 1'b1;
        if (state_q == S_APPLY) begin
          busy_cnt[cur_idx] <= BW'(BUSY_CYCLES);
          pend_q[cur_idx]   <= 1'b0;
          case (op)
            OP_ON:    on_q[cur_idx]    <= data_q[0];
            OP_Y:     y_q[cur_idx]     <= data_q[5:0];
            OP_PAGE:  page_q[cur_idx]  <= data_q[2:0];
            OP_START: start_q[cur_idx] <= data_q[5:0];
            OP_DATA:  y_q[cur_idx]     <= y_q[cur_idx] + 6'd1;
            default:  ;
          endcase
        end
`ifdef LCD_MODEL_RDBACK_EN
        // Data read: latch current byte for the next read, then advance Y.
        if (accept_rd && dori_i) begin
          rd_latch[rd_idx] <= ram[{rd_idx, page_q[rd_idx], y_q[rd_idx]}];
          y_q[rd_idx]      <= y_q[rd_idx] + 6'd1;
        end
`endif
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int unsigned i = 0; i < NUM_CS; i++)
      if (busy_cnt[i] != '0) busy_o = 1'b1;
  end

  assign disp_on_o = on_q;

endmodule

// File: tb/tb_lcd_panel_model.sv
// Randomized self-checking bench for lcd_panel_model against a behavioural panel model.
module tb_lcd_panel_model;
  localparam int unsigned BUSY = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  db_i = '0;
  logic        dori_i = 1'b0;
  logic [3:0]  cs_i = '0;
  logic        en_i = 1'b0;
  logic        rw_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  db_o;
  logic        db_oe;
  logic        busy_o;
  logic [3:0]  disp_on_o;
  logic [10:0] fb_addr_i = '0;
  logic [7:0]  fb_data_o;
  logic        err_o;

  lcd_panel_model #(.NUM_CS(4), .BUSY_CYCLES(BUSY)) dut (
    .clk(clk), .rstn(rstn), .db_i(db_i), .dori_i(dori_i), .cs_i(cs_i),
    .en_i(en_i), .rw_i(rw_i), .rst_i(rst_i), .db_o(db_o), .db_oe(db_oe),
    .busy_o(busy_o), .disp_on_o(disp_on_o), .fb_addr_i(fb_addr_i),
    .fb_data_o(fb_data_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Panel model: per-chip registers, RAM image and which bytes are known.
  int         my[4];
  int         mpage[4];
  int         mon[4];
  bit         merr;
  logic [7:0] mem[2048];
  bit         valid[2048];
  int         addrs_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int maddr(input int c, input int pg, input int y);
    return c * 512 + pg * 64 + y;
  endfunction

  function automatic logic [3:0] mdisp();
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = (mon[c] != 0);
    return v;
  endfunction

  task automatic model_regs_clear();
    for (int c = 0; c < 4; c++) begin my[c] = 0; mpage[c] = 0; mon[c] = 0; end
  endtask

  task automatic model_write(input logic [3:0] cs, input logic dori, input logic [7:0] d,
                             output int exp_busy);
    int v;
    bit legal;
    v = d;
    legal = 1;
    for (int c = 0; c < 4; c++) begin
      if (!cs[c]) continue;
      if (dori) begin
        mem[maddr(c, mpage[c], my[c])] = d;
        valid[maddr(c, mpage[c], my[c])] = 1;
        addrs_q.push_back(maddr(c, mpage[c], my[c]));
        my[c] = (my[c] + 1) % 64;
      end else if (v == 62 || v == 63) mon[c] = v - 62;
      else if (v >= 64 && v < 128)     my[c] = v - 64;
      else if (v >= 184 && v <= 191)   mpage[c] = v - 184;
      else if (v >= 192)               ; // start line: not observable
      else                             legal = 0;
    end
    if (!legal) merr = 1;
    exp_busy = legal ? BUSY + $countones(cs) - 1 : 0;
  endtask

  task automatic bus_write(input logic [3:0] cs, input logic dori, input logic [7:0] d,
                           output int busy_n);
    @(negedge clk);
    cs_i = cs; dori_i = dori; db_i = d; rw_i = 1'b0; en_i = 1'b1;
    @(negedge clk);
    en_i = 1'b0;
    busy_n = 0;
    repeat (11) begin
      @(negedge clk);
      if (busy_o) busy_n++;
    end
    cs_i = '0;
  endtask

  task automatic do_write(input string tag, input logic [3:0] cs, input logic dori,
                          input logic [7:0] d);
    int got_busy, exp_busy;
    bus_write(cs, dori, d, got_busy);
    model_write(cs, dori, d, exp_busy);
    check({tag, ".busy_len"}, got_busy, exp_busy);
    check({tag, ".disp_on"}, disp_on_o, mdisp());
    check({tag, ".err"}, err_o, merr);
  endtask

  task automatic bus_read(input logic [3:0] cs, input logic dori,
                          output logic [7:0] d, output logic oe);
    @(negedge clk);
    cs_i = cs; dori_i = dori; rw_i = 1'b1; en_i = 1'b1;
    @(negedge clk);
    d = db_o; oe = db_oe;
    en_i = 1'b0;
    repeat (4) @(negedge clk);
    rw_i = 1'b0; cs_i = '0;
  endtask

  task automatic fb_check(input string tag, input int a, input logic [7:0] exp);
    logic [31:0] av;
    av = a;
    @(negedge clk);
    fb_addr_i = av[10:0];
    @(negedge clk);
    check(tag, fb_data_o, exp);
  endtask

  task automatic pulse_rstn();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_regs_clear();
    merr = 0;
  endtask

  initial begin
    logic [31:0] rv;
    logic [7:0]  d8;
    logic        oe;
    int          a16;

    model_regs_clear();
    merr = 0;
    for (int a = 0; a < 2048; a++) valid[a] = 0;

    // 1: reset state
    repeat (3) @(negedge clk);
    check("rst.db_o", db_o, 8'h00);
    check("rst.db_oe", db_oe, 1'b0);
    check("rst.busy", busy_o, 1'b0);
    check("rst.disp_on", disp_on_o, 4'b0000);
    check("rst.err", err_o, 1'b0);
    check("rst.fb_data", fb_data_o, 8'h00);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 2: chip0 on, page 1, Y=5, one byte
    do_write("t2.on", 4'b0001, 1'b0, 8'h3F);
    do_write("t2.page", 4'b0001, 1'b0, 8'hB9);
    do_write("t2.y", 4'b0001, 1'b0, 8'h45);
    do_write("t2.data", 4'b0001, 1'b1, 8'hA5);
    fb_check("t2.fb", 69, 8'hA5);
    check("t2.disp_on", disp_on_o, 4'b0001);
    do_write("t2.data2", 4'b0001, 1'b1, 8'h5A);
    fb_check("t2.fb_y6", 70, 8'h5A);

    // 3: Y wrap on chip1, page unchanged
    do_write("t3.y63", 4'b0010, 1'b0, 8'h7F);
    do_write("t3.d11", 4'b0010, 1'b1, 8'h11);
    do_write("t3.d22", 4'b0010, 1'b1, 8'h22);
    fb_check("t3.fb_y63", 512 + 63, 8'h11);
    fb_check("t3.fb_y0", 512, 8'h22);

    // 4: broadcast to all chips
    do_write("t4.y0", 4'b1111, 1'b0, 8'h40);
    do_write("t4.pg0", 4'b1111, 1'b0, 8'hB8);
    do_write("t4.data", 4'b1111, 1'b1, 8'hFF);
    for (int c = 0; c < 4; c++) fb_check("t4.fb", c * 512, 8'hFF);

    // random legal traffic
    for (int n = 0; n < 150; n++) begin
      rv = $urandom;
      d8 = rv[15:8];
      case (rv[2:0])
        3'd0:    d8 = 8'h3E | {7'b0, rv[8]};
        3'd1:    d8 = 8'h40 | {2'b0, rv[13:8]};
        3'd2:    d8 = 8'hB8 | {5'b0, rv[10:8]};
        3'd3:    d8 = 8'hC0 | {2'b0, rv[13:8]};
        default: ;
      endcase
      do_write("rnd", (rv[19:16] == 4'b0) ? 4'b0001 : rv[19:16], rv[2], d8);
      if (addrs_q.size() > 0) begin
        a16 = addrs_q[$urandom_range(addrs_q.size() - 1)];
        fb_check("rnd.fb", a16, mem[a16]);
      end
    end

    // 5: second falling edge while busy decoding, then illegal code
    check("t5.err_pre", err_o, 1'b0);
    do_write("t5.y16", 4'b0001, 1'b0, 8'h50);
    do_write("t5.z16", 4'b0001, 1'b1, 8'h00);
    do_write("t5.z17", 4'b0001, 1'b1, 8'h00);
    do_write("t5.y16b", 4'b0001, 1'b0, 8'h50);
    @(negedge clk);
    cs_i = 4'b0001; dori_i = 1'b1; rw_i = 1'b0; db_i = 8'h33; en_i = 1'b1;
    @(negedge clk); en_i = 1'b0;
    @(negedge clk); en_i = 1'b1; db_i = 8'h44;
    @(negedge clk); en_i = 1'b0;
    repeat (10) @(negedge clk);
    cs_i = '0;
    begin
      int eb;
      model_write(4'b0001, 1'b1, 8'h33, eb);
    end
    merr = 1;
    check("t5.err_drop", err_o, 1'b1);
    fb_check("t5.fb16", maddr(0, mpage[0], 16), 8'h33);
    fb_check("t5.fb17", maddr(0, mpage[0], 17), 8'h00);
    do_write("t5.d77", 4'b0001, 1'b1, 8'h77);
    fb_check("t5.fb17b", maddr(0, mpage[0], 17), 8'h77);
    pulse_rstn();
    check("t5.err_clr", err_o, 1'b0);
    do_write("t5.bad", 4'b0001, 1'b0, 8'h3A);
    check("t5.err_bad", err_o, 1'b1);

`ifdef LCD_MODEL_RDBACK_EN
    // 6: dummy read then real read, status, panel reset keeps RAM
    do_write("t6.y5", 4'b0001, 1'b0, 8'h45);
    do_write("t6.d", 4'b0001, 1'b1, 8'h6C);
    do_write("t6.y5b", 4'b0001, 1'b0, 8'h45);
    bus_read(4'b0001, 1'b1, d8, oe);
    my[0] = (my[0] + 1) % 64;
    bus_read(4'b0001, 1'b1, d8, oe);
    my[0] = (my[0] + 1) % 64;
    check("t6.rd_data", d8, 8'h6C);
    check("t6.rd_oe", oe, 1'b1);
    bus_read(4'b0001, 1'b0, d8, oe);
    check("t6.status", d8, {2'b00, (mon[0] == 0), 5'b0});
    a16 = maddr(0, mpage[0], 5);
    @(negedge clk); rst_i = 1'b0;
    bus_read(4'b0001, 1'b0, d8, oe);
    check("t6.status_rst", d8, 8'h30);
    rst_i = 1'b1;
    model_regs_clear();
    do_write("t6.d99", 4'b0001, 1'b1, 8'h99);
    fb_check("t6.fb_y0", 0, 8'h99);
    fb_check("t6.fb_kept", a16, 8'h6C);
`else
    // reads are ignored entirely without read-back
    bus_read(4'b0001, 1'b1, d8, oe);
    check("t6.no_oe", oe, 1'b0);
    check("t6.no_db", d8, 8'h00);
    do_write("t6.d99", 4'b0001, 1'b1, 8'h99);
`endif

    // final sweep of every byte the model knows
    for (int a = 0; a < 2048; a++)
      if (valid[a]) fb_check("sweep", a, mem[a]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
